// File: rtl/maxpool_c1_pkg.sv
// Shared constants and helpers for the 2x2 stride-2 channel-parallel max-pool stage.
package maxpool_c1_pkg;

  localparam int LANE_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/maxpool_c1_max2_signed.sv
// Combinational two-input signed maximum for one lane; ties return operand a.
module max2_signed #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = ($signed(a_i) >= $signed(b_i)) ? a_i : b_i;

endmodule

// File: rtl/maxpool_c1.sv
// 2x2 stride-2 max pooling over a raster-streamed INPUT_SIZE x INPUT_SIZE map of CHANNEL
// signed lanes: top-row pairs are folded into a half-width row buffer, bottom rows finish the window.
module maxpool_c1
  import maxpool_c1_pkg::*;
#(
  parameter int N          = LANE_W,
  parameter int INPUT_SIZE = 6,
  parameter int CHANNEL    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_vld,
  input  logic [CHANNEL*N-1:0] din,
  output logic [CHANNEL*N-1:0] dout,
  output logic                 dout_vld,
  output logic                 dout_end
);

  localparam int CW   = (clog2(INPUT_SIZE) < 1) ? 1 : clog2(INPUT_SIZE);
  localparam int BUFD = INPUT_SIZE / 2;
  localparam int BW   = (clog2(BUFD) < 1) ? 1 : clog2(BUFD);
  localparam int VW   = CHANNEL * N;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [VW-1:0] hold_q, hold_d;
  logic [VW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          end_q, end_d;
  logic [VW-1:0] rowbuf_q [BUFD];

  logic [BW-1:0] bidx_s;
  logic [VW-1:0] rb_rd_s;
  logic [VW-1:0] max_top_s;
  logic [VW-1:0] max_bot_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          wr_s;

  assign bidx_s     = BW'(col_q >> 1);
  assign rb_rd_s    = rowbuf_q[bidx_s];
  assign col_last_s = (col_q == CW'(INPUT_SIZE - 1));
  assign row_last_s = (row_q == CW'(INPUT_SIZE - 1));

  // u_top folds the held pixel with din; u_bot folds the buffered top-row max with din.
  for (genvar i = 0; i < CHANNEL; i++) begin : g_lane
    localparam int B = lane_base(i, N);

    max2_signed #(.W(N)) u_top (
      .a_i (hold_q[B +: N]),
      .b_i (din[B +: N]),
      .y_o (max_top_s[B +: N])
    );

    max2_signed #(.W(N)) u_bot (
      .a_i (rb_rd_s[B +: N]),
      .b_i (din[B +: N]),
      .y_o (max_bot_s[B +: N])
    );
  end

  // Next-state: position counters, window datapath and frame-end flag.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    end_d  = end_q;
    wr_s   = 1'b0;
    if (din_vld) begin
      end_d = 1'b0;
      if (col_last_s) begin
        col_d = '0;
        if (row_last_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
      case ({row_q[0], col_q[0]})
        2'b00:   hold_d = din;
        2'b01:   wr_s = 1'b1;
        2'b10:   hold_d = max_bot_s;
        2'b11: begin
          dout_d = max_top_s;
          vld_d  = 1'b1;
          // Final window of the frame sets the flag even though a pixel was accepted.
          if (row_last_s && col_last_s) begin
            end_d = 1'b1;
          end else begin
            end_d = 1'b0;
          end
        end
        default: hold_d = hold_q;
      endcase
    end else begin
      vld_d = 1'b0;
    end
  end

  // Control and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      end_q  <= 1'b1;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      end_q  <= end_d;
    end
  end

  // Row buffer of top-row pair maxima; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      rowbuf_q[bidx_s] <= max_top_s;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign dout_end = end_q;

endmodule

// File: tb/tb_maxpool_c1.sv
// Directed bench: 4x4/2-lane instance with hand-computed windows, plus a 6x6/32-lane instance vs a model.
module tb_maxpool_c1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din_vld;
  logic [31:0]  din;
  logic [31:0]  dout;
  logic         dout_vld;
  logic         dout_end;
  logic         din_vld2;
  logic [511:0] din2;
  logic [511:0] dout2;
  logic         dout_vld2;
  logic         dout_end2;

  int n_cmp = 0;
  int n_bad = 0;
  int n_puls;

  logic [31:0]  pix_a [16];
  logic [31:0]  ex_a [4];
  logic [31:0]  last_dout;
  logic [511:0] big_pix [36];
  logic [511:0] big_ex [9];

  always #5 clk = ~clk;

  maxpool_c1 #(.N(16), .INPUT_SIZE(4), .CHANNEL(2)) u_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_end (dout_end)
  );

  maxpool_c1 #(.N(16), .INPUT_SIZE(6), .CHANNEL(32)) u_big (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld2),
    .din      (din2),
    .dout     (dout2),
    .dout_vld (dout_vld2),
    .dout_end (dout_end2)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_s(input logic [31:0] v);
    din     = v;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  task automatic set_ramp();
    for (int p = 0; p < 16; p++) begin
      pix_a[p] = {16'(0 - p), 16'(p)};
    end
    ex_a[0] = 32'h0000_0005;
    ex_a[1] = 32'hFFFE_0007;
    ex_a[2] = 32'hFFF8_000D;
    ex_a[3] = 32'hFFF6_000F;
  endtask

  task automatic do_frame(input bit gaps);
    int w;
    w = 0;
    n_puls = 0;
    for (int p = 0; p < 16; p++) begin
      logic br;
      br = ((p / 4) % 2 == 1) && (p % 2 == 1);
      send_s(pix_a[p]);
      if (dout_vld) n_puls++;
      chk("vld", 512'(dout_vld), 512'(br));
      if (br) begin
        chk("dout", 512'(dout), 512'(ex_a[w]));
        last_dout = ex_a[w];
        w++;
      end
      chk("end", 512'(dout_end), 512'(p == 15));
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 3));
        for (int k = 0; k < g; k++) begin
          @(posedge clk);
          #1;
          chk("gap_vld", 512'(dout_vld), 512'(1'b0));
          chk("gap_dout", 512'(dout), 512'(last_dout));
          chk("gap_end", 512'(dout_end), 512'(p == 15));
        end
      end
    end
    chk("pulses", 512'(n_puls), 512'(4));
  endtask

  initial begin
    int w;
    rst_n    = 1'b1;
    din_vld  = 1'b0;
    din      = 32'h0;
    din_vld2 = 1'b0;
    din2     = 512'h0;
    last_dout = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_dout", 512'(dout), 512'(32'h0));
    chk("rst_vld", 512'(dout_vld), 512'(1'b0));
    chk("rst_end", 512'(dout_end), 512'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;

    set_ramp();
    do_frame(1'b0);
    do_frame(1'b1);

    for (int p = 0; p < 16; p++) pix_a[p] = 32'h0;
    pix_a[0] = 32'h0000_8000;
    pix_a[1] = 32'h0000_7FFF;
    pix_a[4] = 32'h0000_8000;
    pix_a[5] = 32'h0000_8000;
    pix_a[2] = 32'h0000_8000;
    pix_a[3] = 32'h0000_8000;
    pix_a[6] = 32'h0000_8000;
    pix_a[7] = 32'h0000_8000;
    ex_a[0] = 32'h0000_7FFF;
    ex_a[1] = 32'h0000_8000;
    ex_a[2] = 32'h0000_0000;
    ex_a[3] = 32'h0000_0000;
    do_frame(1'b0);

    set_ramp();
    do_frame(1'b0);
    do_frame(1'b0);

    for (int p = 0; p < 7; p++) send_s(pix_a[p]);
    #3;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_dout", 512'(dout), 512'(32'h0));
    chk("mid_rst_vld", 512'(dout_vld), 512'(1'b0));
    chk("mid_rst_end", 512'(dout_end), 512'(1'b1));
    last_dout = 32'h0;
    @(negedge clk);
    rst_n = 1'b0;
    do_frame(1'b0);

    for (int p = 0; p < 36; p++) begin
      for (int l = 0; l < 32; l++) begin
        big_pix[p][l*16 +: 16] = 16'($urandom);
      end
    end
    big_pix[7][15:0]  = 16'h8000;
    big_pix[14][15:0] = 16'h7FFF;
    for (int wy = 0; wy < 3; wy++) begin
      for (int wx = 0; wx < 3; wx++) begin
        for (int l = 0; l < 32; l++) begin
          logic signed [15:0] m;
          logic signed [15:0] v;
          m = big_pix[(2 * wy) * 6 + 2 * wx][l*16 +: 16];
          for (int d = 1; d < 4; d++) begin
            v = big_pix[(2 * wy + d / 2) * 6 + 2 * wx + d % 2][l*16 +: 16];
            if (v > m) m = v;
          end
          big_ex[wy * 3 + wx][l*16 +: 16] = m;
        end
      end
    end
    w = 0;
    n_puls = 0;
    for (int p = 0; p < 36; p++) begin
      logic br;
      br = ((p / 6) % 2 == 1) && (p % 2 == 1);
      din2     = big_pix[p];
      din_vld2 = 1'b1;
      @(posedge clk);
      #1;
      din_vld2 = 1'b0;
      if (dout_vld2) n_puls++;
      chk("big_vld", 512'(dout_vld2), 512'(br));
      if (br) begin
        chk("big_dout", dout2, big_ex[w]);
        w++;
      end
    end
    chk("big_pulses", 512'(n_puls), 512'(9));
    chk("big_end", 512'(dout_end2), 512'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
